serial_bus_receiver: RTL and testbench
======================================

Name: serial_bus_receiver

Overview:
- Receiving end of the bit-serial bus link that carries a WIDTH-bit bus between hierarchy levels over one data wire.
- Deserialises LSB-first bits framed by a last-bit marker and checks frame length. Buffers completed words in a 2-entry output FIFO with a valid/ready handshake.
- Sits between the serial link and a parallel bus consumer, such as a module2-style 2-bit bus sink.

Parameters:
- WIDTH, 2, bus word width in bits; legal values >= 2.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ser_valid  input  1  serial bit present on ser_data.
- ser_data  input  1  serial data bit, LSB of the word first.
- ser_last  input  1  marks the final bit of a word; qualified by ser_valid.
- ser_ready  output  1  receiver accepts a bit this cycle.
- bus_out  output  WIDTH  head-of-FIFO word.
- bus_valid  output  1  bus_out holds a valid word.
- bus_ready  input  1  consumer accepts bus_out this cycle.
- frame_err  output  1  one-cycle pulse on a malformed frame.
- err_count  output  ERR_CNT_W  saturating count of frame errors.

Behaviour:
- Handshakes:
  - A bit is accepted when ser_valid && ser_ready.
  - A word is popped when bus_valid && bus_ready.
  - Nothing changes on cycles without acceptance.
- ser_ready = !fifo_full. It is combinational from FIFO occupancy only; there is no path from bus_ready to ser_ready.
- Internal state: shift register sh[WIDTH-2:0], bit counter cnt (0..WIDTH-1), FSM {SHIFT, DROP}, FIFO count (0..2).
- SHIFT state, on each accepted bit:
  - cnt < WIDTH-1 and !ser_last: sh[cnt] <= ser_data; cnt++.
  - cnt == WIDTH-1 and ser_last: push {ser_data, sh} into the FIFO; cnt <= 0.
  - cnt < WIDTH-1 and ser_last (short frame): discard the word; frame_err=1 next cycle; cnt <= 0; stay in SHIFT.
  - cnt == WIDTH-1 and !ser_last (long frame): discard the word; frame_err=1 next cycle; cnt <= 0; go to DROP.
- DROP state:
  - Accepted bits are discarded.
  - The accepted bit carrying ser_last returns the FSM to SHIFT with cnt=0. That bit belongs to the bad frame and is not counted.
  - No additional frame_err is raised in DROP.
- FIFO:
  - 2 entries. bus_valid = (count != 0). bus_out = head entry, driven from storage, not from the shifter.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Push is impossible when full, because ser_ready is low.
- Latency: the last bit is accepted in cycle N; bus_valid=1 with the word in cycle N+1 if the FIFO was empty.
- err_count increments on every frame_err and saturates at all-ones (no wrap).
- Reset:
  - bus_out=0, bus_valid=0, frame_err=0, err_count=0, cnt=0, FSM=SHIFT, FIFO emptied, ser_ready=1 in the cycle after reset.
  - Reset mid-word discards partial bits and all buffered words.
- ser_data and ser_last are don't-care when ser_valid=0. ser_last on a bit not accepted (ser_ready=0) has no effect.

Test Plan:
- WIDTH=2, bus_ready=1. Send bits 1 then 0, with ser_last on the 2nd bit. Required: bus_out=2'b01 and bus_valid=1 exactly one cycle after the last bit; frame_err stays 0.
- bus_ready=0. Send words 2'b10, 2'b11, then start a third. Required: ser_ready=0 after the 2nd word; no bit of the third word is accepted. Raise bus_ready: 2'b10 then 2'b11 pop in order, and ser_ready returns to 1 the cycle after the first pop.
- Short frame, WIDTH=4: ser_last on the 2nd bit. Required: frame_err pulses 1 cycle, err_count=1, no push. The next well-formed word 4'hA is received correctly.
- Long frame, WIDTH=2: 5 bits with ser_last on the 5th, followed by a good word 2'b11. Required: a single frame_err after bit 2, bits 3-5 dropped, 2'b11 delivered, err_count=1.
- Assert reset after 1 of 2 bits, with 1 word buffered. Required: bus_valid=0 and err_count=0 after reset; a subsequent 2-bit word is received intact without misalignment.
- ERR_CNT_W=2, inject 5 short frames. Required: err_count reads 1, 2, 3, 3, 3 (saturates).

Source files
------------

// File: rtl/serial_bus_receiver.sv
// rtl/serial_bus_receiver.sv - bit-serial LSB-first word receiver with frame check and 2-entry output FIFO
// Shifts framed bits into a word, flags short/long frames, and buffers finished words for a valid/ready consumer.
module serial_bus_receiver #(
  parameter int WIDTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_valid,
  input  logic                 ser_data,
  input  logic                 ser_last,
  output logic                 ser_ready,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {SHIFT, DROP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-2:0]     sh_q, sh_d;
  logic [WIDTH-1:0]     mem_q [2];
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;
  logic                 frame_err_q, frame_err_d;
  logic [ERR_CNT_W-1:0] err_count_q;

  logic             bit_acc, pop, push, cnt_last;
  logic [WIDTH-1:0] push_word;

  // ready depends on occupancy only, so a consumer stall never reaches the link combinationally
  assign ser_ready = (count_q != 2'd2);
  assign bus_valid = (count_q != 2'd0);
  assign bus_out   = mem_q[rd_ptr_q];
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

  assign bit_acc   = ser_valid && ser_ready;
  assign pop       = bus_valid && bus_ready;
  assign cnt_last  = (cnt_q == CNT_W'(WIDTH - 1));
  assign push_word = {ser_data, sh_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    if (bit_acc) begin
      case (state_q)
        SHIFT: begin
          if (cnt_last) begin
            cnt_d = '0;
            if (ser_last) begin
              push = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              state_d     = DROP;
            end
          end else if (ser_last) begin
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            for (int i = 0; i < WIDTH - 1; i++) begin
              if (cnt_q == CNT_W'(i)) sh_d[i] = ser_data;
            end
            cnt_d = cnt_q + 1'b1;
          end
        end
        DROP: begin
          // the closing bit of an overlong frame is swallowed with the rest of it
          if (ser_last) state_d = SHIFT;
          cnt_d = '0;
        end
        default: state_d = SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SHIFT;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      if (frame_err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bus_receiver.sv
// tb/tb_serial_bus_receiver.sv - self-checking bench for serial_bus_receiver
// Drives a WIDTH=2/ERR_CNT_W=2 and a WIDTH=4/ERR_CNT_W=8 instance with shared stimulus against a queue-style reference.
module tb_serial_bus_receiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, ser_valid, ser_data, ser_last, bus_ready;
  logic       ser_ready2, bus_valid2, frame_err2;
  logic [1:0] bus_out2, err_count2;
  logic       ser_ready4, bus_valid4, frame_err4;
  logic [3:0] bus_out4;
  logic [7:0] err_count4;

  serial_bus_receiver #(.WIDTH(2), .ERR_CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last),
    .ser_ready(ser_ready2), .bus_out(bus_out2), .bus_valid(bus_valid2), .bus_ready(bus_ready),
    .frame_err(frame_err2), .err_count(err_count2)
  );

  serial_bus_receiver #(.WIDTH(4), .ERR_CNT_W(8)) u_dut4 (
    .clk(clk), .reset(reset), .ser_valid(ser_valid), .ser_data(ser_data), .ser_last(ser_last),
    .ser_ready(ser_ready4), .bus_out(bus_out4), .bus_valid(bus_valid4), .bus_ready(bus_ready),
    .frame_err(frame_err4), .err_count(err_count4)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference state per instance: bits collected so far, drop flag, FIFO as a head-first list
  int m_n    [2];
  int m_sh   [2];
  bit m_drop [2];
  int m_ec   [2];
  bit m_fe   [2];
  int m_fifo [2][2];
  int m_cnt  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic int emax_of(input int k);
    return (k == 0) ? 3 : 255;
  endfunction

  task automatic model_step(input int k, input bit r, input bit v, input bit d, input bit l, input bit br);
    int w;
    bit rdy;
    w = width_of(k);
    if (r) begin
      m_n[k] = 0; m_sh[k] = 0; m_drop[k] = 0; m_ec[k] = 0; m_fe[k] = 0; m_cnt[k] = 0;
      m_fifo[k][0] = 0; m_fifo[k][1] = 0;
      return;
    end
    rdy     = (m_cnt[k] < 2);
    m_fe[k] = 0;
    if (m_cnt[k] > 0 && br) begin
      m_fifo[k][0] = m_fifo[k][1];
      m_cnt[k]--;
    end
    if (v && rdy) begin
      if (m_drop[k]) begin
        if (l) m_drop[k] = 0;
      end else if (l && m_n[k] == w - 1) begin
        m_fifo[k][m_cnt[k]] = m_sh[k] + (int'(d) << (w - 1));
        m_cnt[k]++;
        m_n[k] = 0; m_sh[k] = 0;
      end else if (l || m_n[k] == w - 1) begin
        m_drop[k] = !l;
        m_fe[k]   = 1;
        if (m_ec[k] < emax_of(k)) m_ec[k]++;
        m_n[k] = 0; m_sh[k] = 0;
      end else begin
        m_sh[k] += int'(d) << m_n[k];
        m_n[k]++;
      end
    end
  endtask

  task automatic check_all();
    check("rdy2", 32'(ser_ready2), 32'(m_cnt[0] < 2));
    check("vld2", 32'(bus_valid2), 32'(m_cnt[0] > 0));
    if (m_cnt[0] > 0) check("out2", 32'(bus_out2), m_fifo[0][0]);
    check("fe2",  32'(frame_err2), 32'(m_fe[0]));
    check("ec2",  32'(err_count2), m_ec[0]);
    check("rdy4", 32'(ser_ready4), 32'(m_cnt[1] < 2));
    check("vld4", 32'(bus_valid4), 32'(m_cnt[1] > 0));
    if (m_cnt[1] > 0) check("out4", 32'(bus_out4), m_fifo[1][0]);
    check("fe4",  32'(frame_err4), 32'(m_fe[1]));
    check("ec4",  32'(err_count4), m_ec[1]);
  endtask

  task automatic cycle(input bit r, input bit v, input bit d, input bit l, input bit br);
    reset = r; ser_valid = v; ser_data = d; ser_last = l; bus_ready = br;
    @(posedge clk);
    model_step(0, r, v, d, l, br);
    model_step(1, r, v, d, l, br);
    @(negedge clk);
    check_all();
  endtask

  int sat_exp [5] = '{1, 2, 3, 3, 3};
  int rem;

  initial begin
    reset = 1'b1; ser_valid = 1'b0; ser_data = 1'b0; ser_last = 1'b0; bus_ready = 1'b1;
    @(negedge clk);

    // reset state and first word, bits 1 then 0
    cycle(1, 0, 0, 0, 1);
    check("rst_out2", 32'(bus_out2), 0);
    check("rst_vld2", 32'(bus_valid2), 0);
    check("rst_rdy2", 32'(ser_ready2), 1);
    check("rst_ec2", 32'(err_count2), 0);
    cycle(0, 1, 1, 0, 1);
    check("t1_early_vld", 32'(bus_valid2), 0);
    cycle(0, 1, 0, 1, 1);
    check("t1_vld", 32'(bus_valid2), 1);
    check("t1_out", 32'(bus_out2), 32'h1);
    check("t1_fe", 32'(frame_err2), 0);
    cycle(0, 0, 0, 0, 1);

    // backpressure: two words fill the FIFO, third word is refused
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 0);
    check("t2_full_rdy", 32'(ser_ready2), 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 0);
    check("t2_still_full", 32'(ser_ready2), 0);
    check("t2_head", 32'(bus_out2), 32'h2);
    cycle(0, 0, 0, 0, 1);
    check("t2_rdy_back", 32'(ser_ready2), 1);
    check("t2_second", 32'(bus_out2), 32'h3);
    cycle(0, 0, 0, 0, 1);
    check("t2_empty", 32'(bus_valid2), 0);

    // short frame on the 4-bit instance, then 4'hA
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 1, 1);
    check("t3_fe", 32'(frame_err4), 1);
    check("t3_ec", 32'(err_count4), 1);
    check("t3_nopush", 32'(bus_valid4), 0);
    cycle(0, 0, 0, 0, 1);
    check("t3_fe_pulse", 32'(frame_err4), 0);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 1, 1);
    check("t3_word", 32'(bus_out4), 32'hA);
    check("t3_word_vld", 32'(bus_valid4), 1);

    // long frame on the 2-bit instance: 5 bits, then 2'b11
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("t4_fe", 32'(frame_err2), 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 0, 1, 1);
    check("t4_drop_vld", 32'(bus_valid2), 0);
    cycle(0, 1, 1, 0, 1);
    cycle(0, 1, 1, 1, 1);
    check("t4_word", 32'(bus_out2), 32'h3);
    check("t4_ec", 32'(err_count2), 1);

    // reset mid-word with a word buffered
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("t5_vld", 32'(bus_valid2), 0);
    check("t5_ec", 32'(err_count2), 0);
    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 1, 1, 1);
    check("t5_word", 32'(bus_out2), 32'h2);

    // error counter saturation on the 2-bit counter
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 1, 1);
      check($sformatf("t6_sat%0d", i), 32'(err_count2), sat_exp[i]);
    end

    // randomized traffic with mixed frame lengths, stalls and occasional resets
    rem = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) begin
        cycle(1, 0, 0, 0, 1);
        rem = 0;
      end else begin
        bit v, d, l, br;
        if (rem == 0) rem = $urandom_range(1, 6);
        v  = ($urandom_range(9) < 7);
        d  = 1'($urandom);
        l  = (rem == 1);
        br = ($urandom_range(9) < 6);
        cycle(0, v, d, l, br);
        if (v) rem--;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
